fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 62 ++++++
 tb/tb_fifo_stream_reader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Reads a ring FIFO whose data arrives one cycle after the read strobe, and buffers it in a 2-entry skid buffer.
// Latency: 2 cycles from read strobe to out_valid. Reads stop while buffered plus in-flight words would exceed 2.
module fifo_stream_reader #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              fifo_read,
    input  logic [DATA_W-1:0] fifo_out,
    input  logic              fifo_val,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        level,
    output logic              err
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              inflight;
    logic              pop;
    logic              push;
    logic [2:0]        occ;

    assign out_valid = (level != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = fifo_val & inflight;

    // Occupancy as seen after this edge's pop; a read is only safe if a slot is left for its response.
    assign occ       = {1'b0, level} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_read = rst & en & (occ < 3'd2);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            level    <= 2'd0;
            inflight <= 1'b0;
            err      <= 1'b0;
        end else begin
            inflight <= fifo_read;
            // One-bit pointers wrap modulo 2 on their own.
            if (push) begin
                mem[wr_ptr] <= fifo_out;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            level <= level + {1'b0, push} - {1'b0, pop};
            if (fifo_val && !inflight) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural ring FIFO plus an in-order scoreboard of returned words.
module tb_fifo_stream_reader;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          fifo_read;
    logic [DW-1:0] fifo_out;
    logic          fifo_val;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    level;
    logic          err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_out = 0;
    int t0;
    int ta;

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic          rd_s;
    logic          inject;
    logic [DW-1:0] inj_word;

    logic          rd_h [1024];
    logic          ov_h [1024];
    logic          er_h [1024];
    logic [DW-1:0] od_h [1024];
    logic [1:0]    lv_h [1024];

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_read (fifo_read),
        .fifo_out  (fifo_out),
        .fifo_val  (fifo_val),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // One cycle: sample outputs, score any transfer, then play the FIFO's response for the next cycle.
    task automatic step();
        logic [DW-1:0] w;
        #1;
        rd_s      = fifo_read;
        rd_h[cyc] = fifo_read;
        ov_h[cyc] = out_valid;
        od_h[cyc] = out_data;
        lv_h[cyc] = level;
        er_h[cyc] = err;
        if (out_valid && out_ready) begin
            n_out++;
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("sb_data", 32'(out_data), 32'(w));
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        fifo_val = 1'b0;
        fifo_out = 8'hEE;
        if (inject) begin
            fifo_val = 1'b1;
            fifo_out = inj_word;
            inject   = 1'b0;
        end else if (rd_s && src_q.size() != 0) begin
            fifo_out = src_q.pop_front();
            fifo_val = 1'b1;
            exp_q.push_back(fifo_out);
        end
    endtask

    task automatic idle(input int n);
        en        = 1'b0;
        out_ready = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; out_ready = 1'b0;
        fifo_val = 1'b0; fifo_out = '0; inject = 1'b0; inj_word = '0;
        #12;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_read",  32'(fifo_read), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Streaming three words at full rate.
        src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
        en = 1'b1; out_ready = 1'b1; n_out = 0; t0 = cyc;
        repeat (6) step();
        for (int i = 0; i < 4; i++) chk("t1_read", 32'(rd_h[t0+i]), 32'd1);
        chk("t1_valid_c1", 32'(ov_h[t0+1]), 32'd0);
        chk("t1_valid_c2", 32'(ov_h[t0+2]), 32'd1);
        chk("t1_data_c2",  32'(od_h[t0+2]), 32'h11);
        chk("t1_data_c3",  32'(od_h[t0+3]), 32'h22);
        chk("t1_data_c4",  32'(od_h[t0+4]), 32'h33);
        chk("t1_valid_c5", 32'(ov_h[t0+5]), 32'd0);
        chk("t1_count", 32'(n_out), 32'd3);
        idle(3);

        // Backpressure: four words, sink stalled, then released.
        for (int i = 0; i < 4; i++) src_q.push_back(8'(8'h41 + i));
        en = 1'b1; out_ready = 1'b0; n_out = 0; t0 = cyc;
        repeat (6) step();
        chk("t2_level_full", 32'(lv_h[t0+3]), 32'd2);
        chk("t2_read_stop",  32'(rd_h[t0+3]), 32'd0);
        chk("t2_read_stop5", 32'(rd_h[t0+5]), 32'd0);
        chk("t2_hold_valid", 32'(ov_h[t0+5]), 32'd1);
        chk("t2_hold_data",  32'(od_h[t0+5]), 32'h41);
        chk("t2_no_out", 32'(n_out), 32'd0);
        out_ready = 1'b1;
        repeat (8) step();
        chk("t2_count", 32'(n_out), 32'd4);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
        idle(3);

        // Empty FIFO, then one word arrives.
        en = 1'b1; out_ready = 1'b1; n_out = 0; t0 = cyc;
        repeat (4) step();
        for (int i = 0; i < 4; i++) begin
            chk("t3_read",  32'(rd_h[t0+i]), 32'd1);
            chk("t3_valid", 32'(ov_h[t0+i]), 32'd0);
            chk("t3_err",   32'(er_h[t0+i]), 32'd0);
        end
        src_q.push_back(8'hA5);
        ta = cyc;
        repeat (4) step();
        chk("t3_valid_n1", 32'(ov_h[ta+1]), 32'd0);
        chk("t3_valid_n2", 32'(ov_h[ta+2]), 32'd1);
        chk("t3_data_n2",  32'(od_h[ta+2]), 32'hA5);
        chk("t3_count", 32'(n_out), 32'd1);
        idle(3);

        // Enable dropped with one read in flight.
        src_q.push_back(8'h61); src_q.push_back(8'h62); src_q.push_back(8'h63);
        en = 1'b1; out_ready = 1'b0; n_out = 0; t0 = cyc;
        step();
        en = 1'b0;
        repeat (4) step();
        chk("t4_read0", 32'(rd_h[t0]), 32'd1);
        for (int i = 1; i < 5; i++) chk("t4_no_read", 32'(rd_h[t0+i]), 32'd0);
        chk("t4_level",  32'(lv_h[t0+2]), 32'd1);
        chk("t4_level4", 32'(lv_h[t0+4]), 32'd1);
        chk("t4_data",   32'(od_h[t0+2]), 32'h61);
        src_q.delete();

        // Unsolicited response while one word is buffered.
        inj_word = 8'h99; inject = 1'b1; t0 = cyc;
        repeat (5) step();
        chk("t5_err_pre",   32'(er_h[t0+1]), 32'd0);
        chk("t5_err_set",   32'(er_h[t0+2]), 32'd1);
        chk("t5_err_stick", 32'(er_h[t0+4]), 32'd1);
        chk("t5_level",     32'(lv_h[t0+2]), 32'd1);
        chk("t5_level4",    32'(lv_h[t0+4]), 32'd1);
        out_ready = 1'b1;
        repeat (2) step();
        chk("t5_count", 32'(n_out), 32'd1);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t5_err_hold", 32'(err), 32'd1);

        // Reset asserted between edges with a full buffer.
        for (int i = 0; i < 4; i++) src_q.push_back(8'(8'h71 + i));
        en = 1'b1; out_ready = 1'b0;
        repeat (5) step();
        #1;
        chk("t6_pre_level", 32'(level), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_read",  32'(fifo_read), 32'd0);
        chk("t6_err",   32'(err), 32'd0);
        src_q.delete();
        exp_q.delete();
        fifo_val = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        src_q.push_back(8'h81);
        en = 1'b1; out_ready = 1'b1; n_out = 0;
        repeat (5) step();
        chk("t6_resume", 32'(n_out), 32'd1);
        chk("t6_err_after", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
